// File: rtl/sprite_ram_write_sched.sv
// rtl/sprite_ram_write_sched.sv - blanking-window write scheduler for the shared sprite RAM
module sprite_ram_write_sched #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int MAX_BURST     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          blank,
    input  logic                          wr_req,
    input  logic [ADDRESS_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    output logic                          wr_ready,
    input  logic [ADDRESS_WIDTH-1:0]      rd_addrPlayer,
    output logic                          ram_wEn,
    output logic [ADDRESS_WIDTH-1:0]      ram_addrPlayer,
    output logic [DATA_WIDTH-1:0]         ram_dataIn,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    logic [ADDRESS_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];

    logic [1:0]               state_q, state_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [BURST_W-1:0]       burst_q, burst_d;
    logic                     ram_wEn_q, ram_wEn_d;
    logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]    ram_dataIn_q, ram_dataIn_d;

    logic                     empty;
    logic                     full;
    logic                     push;
    logic                     pop;
    logic [BURST_W-1:0]       burst_inc;

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        push      = wr_req && !full;
        burst_inc = burst_q + BURST_W'(1);
        pop       = (state_q == S_WRITE) && blank && !empty && (burst_q < BURST_W'(MAX_BURST));

        state_d      = state_q;
        burst_d      = burst_q;
        ram_wEn_d    = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_dataIn_d = ram_dataIn_q;
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (blank && !empty) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (pop) begin
                    ram_wEn_d    = 1'b1;
                    ram_addr_d   = fifo_addr_q[rd_ptr_q];
                    ram_dataIn_d = fifo_data_q[rd_ptr_q];
                    burst_d      = burst_inc;
                    // Keep streaming only if another pop is legal next cycle.
                    if (!(blank && (count_d != '0) && (burst_inc < BURST_W'(MAX_BURST)))) begin
                        state_d = S_RECOVER;
                    end
                end else begin
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: begin
                burst_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                burst_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            burst_q      <= '0;
            ram_wEn_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_dataIn_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            burst_q      <= burst_d;
            ram_wEn_q    <= ram_wEn_d;
            ram_addr_q   <= ram_addr_d;
            ram_dataIn_q <= ram_dataIn_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define which slots are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        wr_ready       = !full;
        ram_wEn        = ram_wEn_q;
        ram_dataIn     = ram_dataIn_q;
        ram_addrPlayer = ram_wEn_q ? ram_addr_q : rd_addrPlayer;
        busy           = (state_q != S_IDLE);
        pending        = count_q;
    end

endmodule

// File: tb/tb_sprite_ram_write_sched.sv
// tb/tb_sprite_ram_write_sched.sv - randomized scoreboard bench for sprite_ram_write_sched
module tb_sprite_ram_write_sched;

    localparam int DEPTH = 4;
    localparam int MAXB  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       blank;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic [7:0] rd_addrPlayer;
    logic       ram_wEn;
    logic [7:0] ram_addrPlayer;
    logic [7:0] ram_dataIn;
    logic       busy;
    logic [2:0] pending;

    int checks = 0;
    int failures = 0;
    int writes_total = 0;
    int run_len = 0;
    logic [15:0] model_q [$];

    sprite_ram_write_sched #(
        .DATA_WIDTH(8), .ADDRESS_WIDTH(8), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)
    ) dut (
        .clk(clk), .reset(reset), .blank(blank), .wr_req(wr_req),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_addrPlayer(rd_addrPlayer), .ram_wEn(ram_wEn),
        .ram_addrPlayer(ram_addrPlayer), .ram_dataIn(ram_dataIn),
        .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive at a falling edge, update the model, check at the next falling edge.
    task automatic step(input logic b, input logic req, input logic [7:0] a, input logic [7:0] d);
        logic [15:0] exp;
        logic        pb;
        blank = b;
        wr_req = req;
        wr_addr = a;
        wr_data = d;
        rd_addrPlayer = 8'($urandom);
        if (req && model_q.size() < DEPTH) model_q.push_back({a, d});
        pb = b;
        @(negedge clk);
        if (ram_wEn === 1'b1) begin
            writes_total++;
            run_len++;
            checks++;
            if (!pb) begin failures++; $display("FAIL pop_outside_blank wEn=%b blank_prev=%b", ram_wEn, pb); end
            checks++;
            if (run_len > MAXB) begin failures++; $display("FAIL burst_limit run=%0d max=%0d", run_len, MAXB); end
            checks++;
            if (busy !== 1'b1) begin failures++; $display("FAIL busy_during_write got=%b exp=1", busy); end
            checks++;
            if (model_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%h data=%h exp=none", ram_addrPlayer, ram_dataIn);
            end else begin
                exp = model_q.pop_front();
                if ({ram_addrPlayer, ram_dataIn} !== exp) begin
                    failures++;
                    $display("FAIL write_order got=%h/%h exp=%h/%h", ram_addrPlayer, ram_dataIn, exp[15:8], exp[7:0]);
                end
            end
        end else begin
            run_len = 0;
            checks++;
            if (ram_wEn !== 1'b0 || ram_addrPlayer !== rd_addrPlayer) begin
                failures++;
                $display("FAIL passthrough wEn=%b addr=%h exp=%h", ram_wEn, ram_addrPlayer, rd_addrPlayer);
            end
        end
        checks++;
        if (pending !== model_q.size()) begin
            failures++;
            $display("FAIL pending got=%0d exp=%0d", pending, model_q.size());
        end
        checks++;
        if (wr_ready !== (model_q.size() < DEPTH)) begin
            failures++;
            $display("FAIL wr_ready got=%b exp=%b", wr_ready, model_q.size() < DEPTH);
        end
        wr_req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        blank = 1'b0;
        wr_req = 1'b0;
        wr_addr = 8'h00;
        wr_data = 8'h00;
        rd_addrPlayer = 8'h00;
        #3;
        checks++;
        if (ram_wEn !== 1'b0 || ram_dataIn !== 8'h00 || busy !== 1'b0 || pending !== 3'd0 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values wEn=%b data=%h busy=%b pend=%0d rdy=%b exp=0/00/0/0/1",
                     ram_wEn, ram_dataIn, busy, pending, wr_ready);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ram_addrPlayer !== 8'h00) begin failures++; $display("FAIL addr_follow0 got=%h exp=00", ram_addrPlayer); end
        rd_addrPlayer = 8'h37;
        #1;
        checks++;
        if (ram_addrPlayer !== 8'h37) begin failures++; $display("FAIL addr_follow37 got=%h exp=37", ram_addrPlayer); end
        @(negedge clk);
        step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_basic;
        logic [5:0] exp_pat;
        logic [5:0] pat;
        int w0;
        exp_pat = 6'b000110;
        step(1'b0, 1'b1, 8'h10, 8'hAA);
        step(1'b0, 1'b1, 8'h11, 8'hBB);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (pending !== 3'd2) begin failures++; $display("FAIL basic_pending2 got=%0d exp=2", pending); end
        w0 = writes_total;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            pat[i] = ram_wEn;
        end
        checks++;
        if (pat !== exp_pat) begin failures++; $display("FAIL basic_pattern got=%b exp=%b", pat, exp_pat); end
        checks++;
        if (writes_total - w0 != 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", writes_total - w0); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle busy=%b exp=0", busy); end
        step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_full;
        int w0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'(8'h20 + i), 8'($urandom));
            if (i == 3) begin
                checks++;
                if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", wr_ready); end
            end
        end
        checks++;
        if (pending !== 3'd4) begin failures++; $display("FAIL full_pending got=%0d exp=4", pending); end
        w0 = writes_total;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
        checks++;
        if (writes_total - w0 != 4) begin failures++; $display("FAIL full_drain got=%0d exp=4", writes_total - w0); end
        step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_burst;
        logic [9:0] exp_pat;
        logic [9:0] pat;
        exp_pat = 10'b0001100110;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 8'($urandom));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            pat[i] = ram_wEn;
        end
        checks++;
        if (pat !== exp_pat) begin failures++; $display("FAIL burst_pattern got=%b exp=%b", pat, exp_pat); end
        checks++;
        if (pending !== 3'd0) begin failures++; $display("FAIL burst_empty got=%0d exp=0", pending); end
        step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_blank_fall;
        int w0;
        int extra;
        int n;
        w0 = writes_total;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 8'($urandom));
        n = 0;
        while (ram_wEn !== 1'b1 && n < 6) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            n++;
        end
        checks++;
        if (ram_wEn !== 1'b1) begin failures++; $display("FAIL fall_first_write wEn=%b exp=1", ram_wEn); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00);
            if (ram_wEn === 1'b1) extra++;
        end
        checks++;
        if (extra > 1) begin failures++; $display("FAIL fall_extra got=%0d exp<=1", extra); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL fall_idle busy=%b exp=0", busy); end
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
        checks++;
        if (writes_total - w0 != 3 || pending !== 3'd0) begin
            failures++;
            $display("FAIL fall_resume writes=%0d pend=%0d exp=3/0", writes_total - w0, pending);
        end
        step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_random;
        logic b;
        int run;
        b = 1'b0;
        run = 0;
        for (int i = 0; i < 400; i++) begin
            if (run == 0) begin
                b = ~b;
                run = $urandom_range(1, 12);
            end
            run--;
            step(b, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
        checks++;
        if (pending !== 3'd0 || model_q.size() != 0) begin
            failures++;
            $display("FAIL random_drain pend=%0d left=%0d exp=0/0", pending, model_q.size());
        end
        step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid;
        int n;
        int w0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 8'($urandom));
        n = 0;
        while (ram_wEn !== 1'b1 && n < 6) begin
            step(1'b1, 1'b0, 8'h00, 8'h00);
            n++;
        end
        checks++;
        if (ram_wEn !== 1'b1 || pending !== 3'd3) begin
            failures++;
            $display("FAIL rstmid_setup wEn=%b pend=%0d exp=1/3", ram_wEn, pending);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ram_wEn !== 1'b0 || pending !== 3'd0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_async wEn=%b pend=%0d busy=%b rdy=%b exp=0/0/0/1", ram_wEn, pending, busy, wr_ready);
        end
        model_q.delete();
        run_len = 0;
        @(negedge clk);
        reset = 1'b0;
        w0 = writes_total;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 8'h00);
        checks++;
        if (writes_total != w0) begin failures++; $display("FAIL rstmid_no_writes got=%0d exp=0", writes_total - w0); end
        step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_burst();
        test_blank_fall();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
